// File: rtl/iq_frame_controller.sv
// iq_frame_controller: buffers CHANNELS-wide I/Q vectors and serialises them as header/payload[/trailer] frames.
// Latency: vector written at edge N gives the header on out_valid after edge N+1; one word per cycle when unstalled.
// Backpressure: out_ready stalls hold the output word; input has none, so a full FIFO drops vectors (counted).
// Build option: define IQ_FRAME_CRC_EN to append an XOR trailer word to each frame.

// Vector FIFO: exposes head and the entry behind it so the framer can move to the next vector without a bubble.
module iq_vec_fifo #(
    parameter int W     = 64,
    parameter int DEPTH = 16,
    parameter int AW    = $clog2(DEPTH),
    parameter int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_push,
    input  logic [W-1:0]     i_dat,
    input  logic             i_pop,
    output logic [W-1:0]     o_head_dat,
    output logic [W-1:0]     o_next_dat,
    output logic [CNT_W-1:0] o_cnt
);
    logic [W-1:0]     r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [CNT_W-1:0] r_cnt;
    logic [AW-1:0]    w_rd_ptr_inc;

    assign w_rd_ptr_inc = r_rd_ptr + AW'(1);
    assign o_head_dat   = r_mem[r_rd_ptr];
    assign o_next_dat   = r_mem[w_rd_ptr_inc];
    assign o_cnt        = r_cnt;

    // Storage write; contents need no reset because occupancy is tracked separately.
    always_ff @(posedge clk) begin
        if (i_push) begin
            r_mem[r_wr_ptr] <= i_dat;
        end
    end

    // Pointers and occupancy; the caller guarantees no push when full without a pop, and no pop when empty.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_cnt    <= '0;
        end else begin
            if (i_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (i_pop) begin
                r_rd_ptr <= w_rd_ptr_inc;
            end
            case ({i_push, i_pop})
                2'b10:   r_cnt <= r_cnt + CNT_W'(1);
                2'b01:   r_cnt <= r_cnt - CNT_W'(1);
                default: r_cnt <= r_cnt;
            endcase
        end
    end
endmodule

module iq_frame_controller #(
    parameter int CHANNELS  = 2,
    parameter int SAMPLE_W  = 16,
    parameter int DEPTH     = 16,
    parameter int FRAME_LEN = 64
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         enable,
    input  logic                         in_valid,
    input  logic [CHANNELS*SAMPLE_W-1:0] in_i,
    input  logic [CHANNELS*SAMPLE_W-1:0] in_q,
    output logic [31:0]                  out_data,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic                         out_last,
    output logic [15:0]                  overflow_cnt,
    output logic [15:0]                  frame_seq
);
    localparam int VEC_W = 2 * CHANNELS * SAMPLE_W;
    localparam int CNT_W = $clog2(DEPTH) + 1;
    localparam int CH_W  = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
    localparam int FL_W  = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
    localparam logic [CH_W-1:0] LAST_CH  = CH_W'(CHANNELS - 1);
    localparam logic [FL_W-1:0] LAST_VEC = FL_W'(FRAME_LEN - 1);

`ifdef IQ_FRAME_CRC_EN
    typedef enum logic [1:0] {S_IDLE, S_HEADER, S_PAYLOAD, S_TRAILER} state_t;
`else
    typedef enum logic [1:0] {S_IDLE, S_HEADER, S_PAYLOAD} state_t;
`endif

    // The state names the kind of word currently held in the output register.
    state_t            r_state, w_nxt_state;
    logic [31:0]       r_out_data, w_nxt_data;
    logic              r_out_valid, w_nxt_valid;
    logic              r_out_last, w_nxt_last;
    logic [CH_W-1:0]   r_ch, w_nxt_ch;
    logic [FL_W-1:0]   r_vec, w_nxt_vec;
    logic [15:0]       r_frame_seq, w_nxt_seq;
    logic [15:0]       r_overflow_cnt;
`ifdef IQ_FRAME_CRC_EN
    logic [31:0]       r_crc, w_nxt_crc;
`endif

    logic              w_push_req;
    logic              w_push;
    logic              w_pop;
    logic              w_drop;
    logic              w_full;
    logic              w_empty;
    logic              w_accept;
    logic [CNT_W-1:0]  w_cnt;
    logic [VEC_W-1:0]  w_head_dat;
    logic [VEC_W-1:0]  w_next_dat;
    logic [CH_W-1:0]   w_ch_inc;
    logic [FL_W-1:0]   w_vec_inc;

    // Pick one channel out of a stored vector {Q lanes, I lanes} and sign-extend both halves to 16 bits.
    function automatic logic [31:0] f_word(input logic [VEC_W-1:0] v, input logic [CH_W-1:0] c);
        logic signed [SAMPLE_W-1:0] s_i;
        logic signed [SAMPLE_W-1:0] s_q;
        s_i = v[int'(c)*SAMPLE_W +: SAMPLE_W];
        s_q = v[(CHANNELS + int'(c))*SAMPLE_W +: SAMPLE_W];
        return {16'(s_q), 16'(s_i)};
    endfunction

    // A payload word ends the frame only when no trailer follows it.
    function automatic logic f_last(input logic [FL_W-1:0] vec, input logic [CH_W-1:0] c);
`ifdef IQ_FRAME_CRC_EN
        return 1'b0 & (vec == LAST_VEC) & (c == LAST_CH);
`else
        return (vec == LAST_VEC) && (c == LAST_CH);
`endif
    endfunction

    assign w_push_req = in_valid && enable;
    assign w_full     = (w_cnt == CNT_W'(DEPTH));
    assign w_empty    = (w_cnt == '0);
    assign w_accept   = r_out_valid && out_ready;
    // A vector leaves the FIFO once its last channel word has been taken by the sink.
    assign w_pop      = (r_state == S_PAYLOAD) && w_accept && (r_ch == LAST_CH);
    // A simultaneous pop frees the slot, so a full FIFO still accepts on that edge.
    assign w_push     = w_push_req && (!w_full || w_pop);
    assign w_drop     = w_push_req && w_full && !w_pop;
    assign w_ch_inc   = r_ch + CH_W'(1);
    assign w_vec_inc  = r_vec + FL_W'(1);

    iq_vec_fifo #(
        .W     (VEC_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk        (clk),
        .rst        (rst),
        .i_push     (w_push),
        .i_dat      ({in_q, in_i}),
        .i_pop      (w_pop),
        .o_head_dat (w_head_dat),
        .o_next_dat (w_next_dat),
        .o_cnt      (w_cnt)
    );

    // Next word selection: the output register only changes when empty or when its word is accepted.
    always_comb begin
        w_nxt_state = r_state;
        w_nxt_data  = r_out_data;
        w_nxt_valid = r_out_valid;
        w_nxt_last  = r_out_last;
        w_nxt_ch    = r_ch;
        w_nxt_vec   = r_vec;
        w_nxt_seq   = r_frame_seq;
`ifdef IQ_FRAME_CRC_EN
        w_nxt_crc   = r_crc;
`endif
        case (r_state)
            S_IDLE: begin
                if (!w_empty) begin
                    w_nxt_state = S_HEADER;
                    w_nxt_data  = {16'hA5A5, r_frame_seq};
                    w_nxt_valid = 1'b1;
                    w_nxt_last  = 1'b0;
                    w_nxt_ch    = '0;
                    w_nxt_vec   = '0;
`ifdef IQ_FRAME_CRC_EN
                    w_nxt_crc   = '0;
`endif
                end
            end
            S_HEADER: begin
                // The vector that triggered the header cannot have left the FIFO yet.
                if (w_accept) begin
                    w_nxt_state = S_PAYLOAD;
                    w_nxt_data  = f_word(w_head_dat, '0);
                    w_nxt_valid = 1'b1;
                    w_nxt_last  = f_last('0, '0);
                end
            end
            S_PAYLOAD: begin
                if (!r_out_valid) begin
                    // Underrun recovery: r_ch/r_vec already point at the awaited word.
                    if (!w_empty) begin
                        w_nxt_data  = f_word(w_head_dat, r_ch);
                        w_nxt_valid = 1'b1;
                        w_nxt_last  = f_last(r_vec, r_ch);
                    end
                end else if (w_accept) begin
`ifdef IQ_FRAME_CRC_EN
                    w_nxt_crc = r_crc ^ r_out_data;
`endif
                    if (r_ch == LAST_CH) begin
                        if (r_vec == LAST_VEC) begin
`ifdef IQ_FRAME_CRC_EN
                            w_nxt_state = S_TRAILER;
                            w_nxt_data  = r_crc ^ r_out_data;
                            w_nxt_valid = 1'b1;
                            w_nxt_last  = 1'b1;
`else
                            w_nxt_state = S_IDLE;
                            w_nxt_valid = 1'b0;
                            w_nxt_last  = 1'b0;
                            w_nxt_seq   = r_frame_seq + 16'd1;
`endif
                        end else begin
                            w_nxt_vec = w_vec_inc;
                            w_nxt_ch  = '0;
                            // The head is being popped now, so the next vector sits one entry behind it.
                            if (w_cnt > CNT_W'(1)) begin
                                w_nxt_data  = f_word(w_next_dat, '0);
                                w_nxt_valid = 1'b1;
                                w_nxt_last  = f_last(w_vec_inc, '0);
                            end else begin
                                w_nxt_valid = 1'b0;
                                w_nxt_last  = 1'b0;
                            end
                        end
                    end else begin
                        w_nxt_ch   = w_ch_inc;
                        w_nxt_data = f_word(w_head_dat, w_ch_inc);
                        w_nxt_last = f_last(r_vec, w_ch_inc);
                    end
                end
            end
`ifdef IQ_FRAME_CRC_EN
            S_TRAILER: begin
                if (w_accept) begin
                    w_nxt_state = S_IDLE;
                    w_nxt_valid = 1'b0;
                    w_nxt_last  = 1'b0;
                    w_nxt_seq   = r_frame_seq + 16'd1;
                end
            end
`endif
            default: begin
                w_nxt_state = S_IDLE;
                w_nxt_valid = 1'b0;
                w_nxt_last  = 1'b0;
            end
        endcase
    end

    // Framer state and registered outputs; reset abandons any frame in progress.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_out_data  <= '0;
            r_out_valid <= 1'b0;
            r_out_last  <= 1'b0;
            r_ch        <= '0;
            r_vec       <= '0;
            r_frame_seq <= '0;
`ifdef IQ_FRAME_CRC_EN
            r_crc       <= '0;
`endif
        end else begin
            r_state     <= w_nxt_state;
            r_out_data  <= w_nxt_data;
            r_out_valid <= w_nxt_valid;
            r_out_last  <= w_nxt_last;
            r_ch        <= w_nxt_ch;
            r_vec       <= w_nxt_vec;
            r_frame_seq <= w_nxt_seq;
`ifdef IQ_FRAME_CRC_EN
            r_crc       <= w_nxt_crc;
`endif
        end
    end

    // Dropped-vector counter, saturating so a long overload never reads as a small number.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_overflow_cnt <= '0;
        end else if (w_drop && (r_overflow_cnt != 16'hFFFF)) begin
            r_overflow_cnt <= r_overflow_cnt + 16'd1;
        end
    end

    assign out_data     = r_out_data;
    assign out_valid    = r_out_valid;
    assign out_last     = r_out_last;
    assign overflow_cnt = r_overflow_cnt;
    assign frame_seq    = r_frame_seq;
endmodule
